seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised successor to the team's fixed 3-bit Mealy control FSM.
- Detects a compile-time bit pattern of arbitrary width on a serial input.
- Adds run-time overlap/non-overlap mode, input qualification (enable), synchronous clear, and a saturating hit counter.
- Sits in the control path: it consumes a 1-bit stream and produces a registered 1-cycle match pulse plus statistics.

Parameters:
- PAT_W, 3, pattern length in bits (>=2).
- PATTERN, 3'b110, target pattern; MSB is the first bit received.
- CNT_W, 8, hit counter width (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  x is sampled only when en=1.
- x  input  1  serial data bit.
- overlap  input  1  1: overlapping matches allowed; 0: history restarts after each match.
- clr  input  1  synchronous clear of history, counter and y.
- y  output  1  registered match pulse.
- hit_cnt  output  CNT_W  number of matches, saturating.
- cnt_sat  output  1  high while hit_cnt is all ones.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (nrst).
- Reset (nrst=0, asynchronous): hist=0, fill=0, state=IDLE, y=0, hit_cnt=0, cnt_sat=0.
- Internal state:
  - hist[PAT_W-1:0] is the shift history; the newest bit is at LSB.
  - fill[$clog2(PAT_W+1)-1:0] is the number of valid history bits.
- FSM is encoded by fill:
  - IDLE: fill=0.
  - FILLING: 0<fill<PAT_W.
  - ARMED: fill=PAT_W.
- Per clock, priority order is nrst > clr > en.
- clr=1: hist=0, fill=0, y=0, hit_cnt=0, cnt_sat=0. Any bit presented this cycle is discarded, even if it would complete a match.
- en=0: hist, fill and hit_cnt hold; y=0 the next cycle. Disabled cycles are invisible to the detector.
- en=1:
  - hist_n = {hist[PAT_W-2:0], x}.
  - fill_n = min(fill+1, PAT_W).
  - match = (fill_n==PAT_W) && (hist_n==PATTERN).
- On match:
  - y=1 next cycle.
  - hit_cnt increments unless already all ones.
  - overlap=1: fill stays PAT_W (ARMED); the next match can share bits.
  - overlap=0: fill=0 (IDLE); the matched bits are discarded.
- No match: y=0; hist=hist_n; fill=fill_n.
- Transitions:
  - IDLE->FILLING on an en cycle.
  - FILLING->ARMED when fill_n reaches PAT_W.
  - ARMED->IDLE on a match with overlap=0, or on clr.
  - Any state->IDLE on clr.
- Latency: y rises on the clock edge that samples the last pattern bit and lasts exactly 1 cycle per match. Consecutive matches (overlap=1, e.g. pattern 11 on a stream of all ones) give y high on consecutive cycles.
- overlap is sampled only on the matching cycle; changing it mid-stream affects only that restart decision.
- Counter: cnt_sat = &hit_cnt, registered together with hit_cnt. At saturation y still pulses; hit_cnt holds.
- An all-zero PATTERN still requires PAT_W valid bits, so no match is possible directly after reset or clr.
- x and en are synchronous to clk; no internal synchroniser.

Decomposition:
- Shared package: state encoding constants (ST_IDLE/ST_FILLING/ST_ARMED for assertions and coverage) and the FILL_W = $clog2(PAT_W+1) width function.
- One sub-module: sat_counter (parameter W; ports clk, nrst, clr, inc, cnt, sat).
- Pattern shift/compare logic stays in the top level.

Test Plan:
1. Defaults (PAT_W=3, PATTERN=110), en=1, x=1,1,0 after reset -> y=1 for exactly one cycle, aligned with the edge after the third bit; hit_cnt=1. Next x=0 -> y=0.
2. PAT_W=4, PATTERN=1010, x=1,0,1,0,1,0:
   - overlap=1 -> y pulses after bit 4 and bit 6, hit_cnt=2.
   - overlap=0 -> single pulse after bit 4, hit_cnt=1.
3. Defaults, x=1 (en=1), three cycles with en=0 and x=0, then x=1,0 with en=1 -> one match, hit_cnt=1; y=0 during all en=0 cycles.
4. CNT_W=2, five separate 110 sequences -> hit_cnt sequence 1,2,3,3,3; cnt_sat=1 from the third hit; y pulses all five times.
5. Defaults, x=1,1, pulse nrst low mid-cycle, then x=0 -> y stays 0, hit_cnt=0 (history lost). Then x=1,1,0 -> match.
6. Defaults, x=1,1, then x=0 with clr=1 on the same cycle -> no y, hit_cnt=0, fill=0. Then x=1,1,0 -> y=1, hit_cnt=1.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_detector_param_pkg
// Brief  : Shared state encoding and width helper for the pattern detector.
// Rev    : 1.0  initial release
// ============================================================================
package seq_detector_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } state_e;

    // Width needed to hold a fill count ranging over 0..pat_w inclusive.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear and registered flag.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         sat_q;
    logic         sat_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat_q) begin
            cnt_d = cnt_q + W'(1);
        end
        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module : seq_detector_param
// Brief  : Serial bit-pattern detector with overlap mode, enable, clear and
//          saturating hit counter. Registered one-cycle match pulse.
// Rev    : 1.0  initial release
// ============================================================================
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clr,
    output logic             y,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              y_q;
    logic              y_d;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              match;
    state_e            state;

    // The FSM state is fully implied by how many history bits are valid.
    always_comb begin
        if (fill_q == '0) begin
            state = ST_IDLE;
        end else if (fill_q == FILL_FULL) begin
            state = ST_ARMED;
        end else begin
            state = ST_FILLING;
        end
    end

    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], x};
        fill_n = (state == ST_ARMED) ? FILL_FULL : fill_q + FILL_W'(1);
        match  = !clr && en && (fill_n == FILL_FULL) && (hist_n == PATTERN);

        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_n;
            if (match) begin
                y_d    = 1'b1;
                fill_d = overlap ? FILL_FULL : '0;
            end else begin
                fill_d = fill_n;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .nrst (nrst),
        .clr  (clr),
        .inc  (match),
        .cnt  (hit_cnt),
        .sat  (cnt_sat)
    );

    assign y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_detector_param
// Brief  : Self-checking bench for seq_detector_param in three configurations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic en = 1'b0;
    logic x = 1'b0;
    logic overlap = 1'b1;
    logic clr = 1'b0;

    logic       y_def, sat_def;
    logic [7:0] cnt_def;
    logic       y_p4, sat_p4;
    logic [7:0] cnt_p4;
    logic       y_c2, sat_c2;
    logic [1:0] cnt_c2;

    always #5 clk = ~clk;

    seq_detector_param u_def (
        .clk (clk), .nrst (nrst), .en (en), .x (x), .overlap (overlap), .clr (clr),
        .y (y_def), .hit_cnt (cnt_def), .cnt_sat (sat_def)
    );

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8)) u_p4 (
        .clk (clk), .nrst (nrst), .en (en), .x (x), .overlap (overlap), .clr (clr),
        .y (y_p4), .hit_cnt (cnt_p4), .cnt_sat (sat_p4)
    );

    seq_detector_param #(.PAT_W(3), .PATTERN(3'b110), .CNT_W(2)) u_c2 (
        .clk (clk), .nrst (nrst), .en (en), .x (x), .overlap (overlap), .clr (clr),
        .y (y_c2), .hit_cnt (cnt_c2), .cnt_sat (sat_c2)
    );

    typedef struct {
        int    sel;
        logic  ey;
        int    ecnt;
        logic  esat;
        string nm;
    } exp_t;

    typedef struct {
        logic en;
        logic x;
        logic ov;
        logic clr;
        logic ey;
        int   ecnt;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        logic ay, asat;
        int   acnt;
        e = sb.pop_front();
        case (e.sel)
            1:       begin ay = y_p4;  acnt = int'(cnt_p4);  asat = sat_p4;  end
            2:       begin ay = y_c2;  acnt = int'(cnt_c2);  asat = sat_c2;  end
            default: begin ay = y_def; acnt = int'(cnt_def); asat = sat_def; end
        endcase
        check({e.nm, ".y"},   int'(ay),   int'(e.ey));
        check({e.nm, ".cnt"}, acnt,       e.ecnt);
        check({e.nm, ".sat"}, int'(asat), int'(e.esat));
    endtask

    task automatic step(input int sel, input logic e, input logic xi, input logic ov,
                        input logic c, input logic ey, input int ecnt, input logic esat,
                        input string nm);
        en      = e;
        x       = xi;
        overlap = ov;
        clr     = c;
        sb.push_back('{sel, ey, ecnt, esat, nm});
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic do_reset();
        en   = 1'b0;
        clr  = 1'b0;
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    vec_t t1[4];
    vec_t t3[6];

    initial begin
        t1[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        t1[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        t1[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        t1[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};

        t3[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        t3[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        t3[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        t3[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        t3[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        t3[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};

        do_reset();
        check("reset.def.y",   int'(y_def),   0);
        check("reset.def.cnt", int'(cnt_def), 0);
        check("reset.c2.sat",  int'(sat_c2),  0);

        // Basic 110 detection
        foreach (t1[i])
            step(0, t1[i].en, t1[i].x, t1[i].ov, t1[i].clr, t1[i].ey, t1[i].ecnt, 1'b0,
                 $sformatf("t1[%0d]", i));

        // 1010 with overlap then without
        do_reset();
        step(1, 1, 1, 1, 0, 0, 0, 0, "t2o.b1");
        step(1, 1, 0, 1, 0, 0, 0, 0, "t2o.b2");
        step(1, 1, 1, 1, 0, 0, 0, 0, "t2o.b3");
        step(1, 1, 0, 1, 0, 1, 1, 0, "t2o.b4");
        step(1, 1, 1, 1, 0, 0, 1, 0, "t2o.b5");
        step(1, 1, 0, 1, 0, 1, 2, 0, "t2o.b6");
        do_reset();
        step(1, 1, 1, 0, 0, 0, 0, 0, "t2n.b1");
        step(1, 1, 0, 0, 0, 0, 0, 0, "t2n.b2");
        step(1, 1, 1, 0, 0, 0, 0, 0, "t2n.b3");
        step(1, 1, 0, 0, 0, 1, 1, 0, "t2n.b4");
        step(1, 1, 1, 0, 0, 0, 1, 0, "t2n.b5");
        step(1, 1, 0, 0, 0, 0, 1, 0, "t2n.b6");

        // Enable gaps are invisible to the detector
        do_reset();
        foreach (t3[i])
            step(0, t3[i].en, t3[i].x, t3[i].ov, t3[i].clr, t3[i].ey, t3[i].ecnt, 1'b0,
                 $sformatf("t3[%0d]", i));

        // 2-bit counter saturation, then clear
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(2, 1, 1, 1, 0, 0, (k > 2) ? 3 : k, (k > 2), $sformatf("t4.%0d.a", k));
            step(2, 1, 1, 1, 0, 0, (k > 2) ? 3 : k, (k > 2), $sformatf("t4.%0d.b", k));
            step(2, 1, 0, 1, 0, 1, (k >= 2) ? 3 : k + 1, (k >= 2), $sformatf("t4.%0d.c", k));
        end
        step(2, 1, 1, 1, 1, 0, 0, 0, "t4.clr");

        // Asynchronous reset mid-stream loses history
        do_reset();
        step(0, 1, 1, 1, 0, 0, 0, 0, "t5.a");
        step(0, 1, 1, 1, 0, 0, 0, 0, "t5.b");
        #2;
        nrst = 1'b0;
        #1;
        check("t5.async.y", int'(y_def), 0);
        nrst = 1'b1;
        step(0, 1, 0, 1, 0, 0, 0, 0, "t5.c");
        step(0, 1, 1, 1, 0, 0, 0, 0, "t5.d");
        step(0, 1, 1, 1, 0, 0, 0, 0, "t5.e");
        step(0, 1, 0, 1, 0, 1, 1, 0, "t5.f");

        // Clear on the completing bit discards it
        do_reset();
        step(0, 1, 1, 1, 0, 0, 0, 0, "t6.a");
        step(0, 1, 1, 1, 0, 0, 0, 0, "t6.b");
        step(0, 1, 0, 1, 1, 0, 0, 0, "t6.clr");
        step(0, 1, 0, 1, 0, 0, 0, 0, "t6.c");
        step(0, 1, 1, 1, 0, 0, 0, 0, "t6.d");
        step(0, 1, 1, 1, 0, 0, 0, 0, "t6.e");
        step(0, 1, 0, 1, 0, 1, 1, 0, "t6.f");

        check("sb.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
